// File: rtl/m68k_dtack_generator.sv
// 68000 bus-cycle acknowledge: per-region wait states, DRAM DTACK
// forwarding and a watchdog that raises BERR on unmapped/hung cycles.
module m68k_dtack_generator #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 3,
  parameter int unsigned CAN_WAIT = 6,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic Clk,
  input  logic Reset_L,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic CanBusSelect_H,
  input  logic DramSelect_H,
  input  logic DramDtack_L,
  output logic DtackOut_L,
  output logic BErr_L,
  output logic BusCycleActive_H
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ACK, S_BERR
  } state_t;

  typedef enum logic [2:0] {
    R_ROM, R_RAM, R_IO, R_CAN, R_DRAM, R_UNMAP
  } region_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  region_t     region_q, region_d;
  region_t     sel_region;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  sel_wait;
  logic [15:0] tmo_q, tmo_d;
  logic        dram_q, dram_d;
  logic        dtack_q, dtack_d;
  logic        berr_q, berr_d;
  logic        busy_q, busy_d;
  logic        start;
  logic        ack_ok;
  logic        tmo_hit;

  // Decode the region select with fixed priority and its wait count
  always_comb begin
    sel_region = R_UNMAP;
    sel_wait   = 4'd0;
    priority case (1'b1)
      OnChipRomSelect_H: begin
        sel_region = R_ROM;
        sel_wait   = 4'(ROM_WAIT);
      end
      OnChipRamSelect_H: begin
        sel_region = R_RAM;
        sel_wait   = 4'(RAM_WAIT);
      end
      IOSelect_H: begin
        sel_region = R_IO;
        sel_wait   = 4'(IO_WAIT);
      end
      CanBusSelect_H: begin
        sel_region = R_CAN;
        sel_wait   = 4'(CAN_WAIT);
      end
      DramSelect_H: begin
        sel_region = R_DRAM;
      end
      default: begin
        sel_region = R_UNMAP;
      end
    endcase
  end

  // Next-state logic for the bus-cycle FSM and its counters
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wait_d   = wait_q;
    tmo_d    = tmo_q;
    dtack_d  = dtack_q;
    berr_d   = berr_q;
    start    = !AS_L && (!UDS_L || !LDS_L);
    dram_d   = (state_q == S_WAIT) && !DramDtack_L;
    ack_ok   = 1'b0;
    tmo_hit  = (tmo_q == TMO_LAST);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WAIT;
          region_d = sel_region;
          wait_d   = sel_wait;
          tmo_d    = 16'd0;
        end
      end
      S_WAIT: begin
        if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
        if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
        unique case (region_q)
          R_DRAM:  ack_ok = dram_q;
          R_UNMAP: ack_ok = 1'b0;
          default: ack_ok = (wait_q == 4'd0);
        endcase
        if (AS_L) begin
          state_d = S_IDLE;
        end else if (ack_ok) begin
          state_d = S_ACK;
          dtack_d = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_BERR;
          berr_d  = 1'b0;
        end
      end
      S_ACK: begin
        if (AS_L) begin
          state_d = S_IDLE;
          dtack_d = 1'b1;
        end
      end
      S_BERR: begin
        if (AS_L) begin
          state_d = S_IDLE;
          berr_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= S_IDLE;
      region_q <= R_UNMAP;
      wait_q   <= 4'd0;
      tmo_q    <= 16'd0;
      dram_q   <= 1'b0;
      dtack_q  <= 1'b1;
      berr_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
      dram_q   <= dram_d;
      dtack_q  <= dtack_d;
      berr_q   <= berr_d;
      busy_q   <= busy_d;
    end
  end

  assign DtackOut_L       = dtack_q;
  assign BErr_L           = berr_q;
  assign BusCycleActive_H = busy_q;

endmodule

// File: tb/tb_m68k_dtack_generator.sv
// Scoreboard bench for m68k_dtack_generator: randomized 68000 cycles
// against a timing model; a monitor thread checks DTACK/BERR edges.
module tb_m68k_dtack_generator;

  localparam int ROM_W = 1;
  localparam int RAM_W = 0;
  localparam int IO_W  = 3;
  localparam int CAN_W = 6;
  localparam int TMO   = 20;
  localparam int NEVER = 1 << 30;

  logic Clk = 1'b0;
  logic Reset_L = 1'b0;
  logic AS_L = 1'b1;
  logic UDS_L = 1'b1;
  logic LDS_L = 1'b1;
  logic OnChipRomSelect_H = 1'b0;
  logic OnChipRamSelect_H = 1'b0;
  logic IOSelect_H = 1'b0;
  logic CanBusSelect_H = 1'b0;
  logic DramSelect_H = 1'b0;
  logic DramDtack_L = 1'b1;
  logic DtackOut_L;
  logic BErr_L;
  logic BusCycleActive_H;

  m68k_dtack_generator #(
    .ROM_WAIT(ROM_W),
    .RAM_WAIT(RAM_W),
    .IO_WAIT (IO_W),
    .CAN_WAIT(CAN_W),
    .TIMEOUT (TMO)
  ) dut (
    .Clk              (Clk),
    .Reset_L          (Reset_L),
    .AS_L             (AS_L),
    .UDS_L            (UDS_L),
    .LDS_L            (LDS_L),
    .OnChipRomSelect_H(OnChipRomSelect_H),
    .OnChipRamSelect_H(OnChipRamSelect_H),
    .IOSelect_H       (IOSelect_H),
    .CanBusSelect_H   (CanBusSelect_H),
    .DramSelect_H     (DramSelect_H),
    .DramDtack_L      (DramDtack_L),
    .DtackOut_L       (DtackOut_L),
    .BErr_L           (BErr_L),
    .BusCycleActive_H (BusCycleActive_H)
  );

  always #5 Clk = ~Clk;

  int edge_n = 0;
  always @(posedge Clk) edge_n <= edge_n + 1;

  typedef struct {
    int kind;
    int as_e;
    int rel_e;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_run = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)",
               name, act, exp, edge_n);
    end
  endtask

  task automatic on_fall(input int kind);
    if (sb.size() == 0) begin
      check("unexpected_response", kind, -1);
    end else begin
      cur = sb.pop_front();
      have_cur = 1'b1;
      check("resp_kind", kind, cur.kind);
      check("resp_edge", edge_n, cur.as_e);
      check("busy_at_resp", int'(BusCycleActive_H), 1);
    end
  endtask

  task automatic on_rise(input int kind);
    if (!have_cur) begin
      check("release_without_resp", kind, -1);
    end else begin
      check("release_kind", kind, cur.kind);
      check("release_edge", edge_n, cur.rel_e);
      have_cur = 1'b0;
    end
  endtask

  task automatic monitor();
    logic pd;
    logic pb;
    pd = 1'b1;
    pb = 1'b1;
    while (mon_run) begin
      @(negedge Clk);
      check("never_both_low", int'(DtackOut_L | BErr_L), 1);
      if (pd && !DtackOut_L) on_fall(0);
      if (!pd && DtackOut_L) on_rise(0);
      if (pb && !BErr_L) on_fall(1);
      if (!pb && BErr_L) on_rise(1);
      pd = DtackOut_L;
      pb = BErr_L;
    end
  endtask

  function automatic int wait_of(input int r);
    case (r)
      0: return ROM_W;
      1: return RAM_W;
      2: return IO_W;
      3: return CAN_W;
      default: return 0;
    endcase
  endfunction

  task automatic drive_idle();
    AS_L = 1'b1;
    UDS_L = 1'b1;
    LDS_L = 1'b1;
    {DramSelect_H, CanBusSelect_H, IOSelect_H,
     OnChipRamSelect_H, OnChipRomSelect_H} = 5'($urandom);
    DramDtack_L = 1'b1;
  endtask

  // r: 0 ROM,1 RAM,2 IO,3 CAN,4 DRAM,5 unmapped
  // s: edge offset at which DRAM DTACK is first seen low
  // k: abort offset (0 = none); h: edges held after response
  // st: 0 LDS, 1 UDS, 2 both, -1 random
  task automatic run_cycle(input int r, input int s, input int k,
                           input int h, input int pre, input int gap,
                           input int st);
    int a;
    int kind;
    int resp;
    int fin;
    int e0;
    int stv;
    logic [4:0] sel;
    repeat (pre) begin
      AS_L = 1'b0;
      UDS_L = 1'b1;
      LDS_L = 1'b1;
      DramDtack_L = 1'b1;
      @(negedge Clk);
    end
    e0 = edge_n + 1;
    if (r < 4) a = wait_of(r) + 1;
    else if (r == 4) a = s + 1;
    else a = NEVER;
    if (a <= TMO) begin
      kind = 0;
      resp = a;
    end else begin
      kind = 1;
      resp = TMO;
    end
    if (k > 0 && k <= resp) begin
      fin = k;
    end else begin
      fin = resp + h;
      sb.push_back('{kind, e0 + resp, e0 + fin});
    end
    stv = (st < 0) ? int'($urandom_range(0, 2)) : st;
    for (int o = 0; o <= fin; o++) begin
      if (o == fin) begin
        drive_idle();
      end else begin
        AS_L = 1'b0;
        UDS_L = (stv == 0);
        LDS_L = (stv == 1);
        if (o == 0) begin
          for (int j = 0; j < 5; j++)
            sel[j] = (j == r) ||
                     (j > r && r < 5 && $urandom_range(0, 1) == 1);
        end else begin
          sel = 5'($urandom);
        end
        {DramSelect_H, CanBusSelect_H, IOSelect_H,
         OnChipRamSelect_H, OnChipRomSelect_H} = sel;
        if (r == 4) DramDtack_L = !(o >= s);
        else DramDtack_L = (o == 0) ? 1'b1 : 1'($urandom);
      end
      @(negedge Clk);
    end
    repeat (gap) begin
      drive_idle();
      @(negedge Clk);
    end
  endtask

  task automatic reset_mid_ack();
    int e0;
    e0 = edge_n + 1;
    sb.push_back('{0, e0 + ROM_W + 1, e0 + 4});
    for (int o = 0; o < 4; o++) begin
      AS_L = 1'b0;
      LDS_L = 1'b0;
      UDS_L = 1'b1;
      {DramSelect_H, CanBusSelect_H, IOSelect_H,
       OnChipRamSelect_H, OnChipRomSelect_H} = 5'b00001;
      @(negedge Clk);
    end
    @(posedge Clk);
    #1;
    Reset_L = 1'b0;
    #1;
    check("rst_dtack_async", int'(DtackOut_L), 1);
    check("rst_berr_async", int'(BErr_L), 1);
    check("rst_busy_async", int'(BusCycleActive_H), 0);
    @(negedge Clk);
    drive_idle();
    @(negedge Clk);
    Reset_L = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    fork
      monitor();
    join_none
    #12;
    check("reset_dtack", int'(DtackOut_L), 1);
    check("reset_berr", int'(BErr_L), 1);
    check("reset_busy", int'(BusCycleActive_H), 0);
    @(negedge Clk);
    Reset_L = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    run_cycle(0, 1, 0, 1, 0, 1, 0);
    run_cycle(2, 1, 0, 2, 0, 0, 2);
    run_cycle(4, 5, 0, 3, 0, 1, 2);
    run_cycle(5, 1, 0, 2, 0, 1, 1);
    run_cycle(3, 1, 3, 1, 0, 1, 0);
    run_cycle(1, 1, 0, 1, 2, 0, 1);
    run_cycle(4, 19, 0, 1, 0, 0, 0);
    run_cycle(4, 20, 0, 1, 0, 0, 0);
    run_cycle(4, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      run_cycle(int'($urandom_range(0, 5)),
                int'($urandom_range(1, 22)),
                ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(1, 8)) : 0,
                int'($urandom_range(1, 3)),
                int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)),
                -1);
    end
    reset_mid_ack();
    run_cycle(0, 1, 0, 2, 0, 1, 0);
    repeat (4) @(negedge Clk);
    mon_run = 1'b0;
    @(negedge Clk);
    check("scoreboard_empty", sb.size(), 0);
    check("no_open_response", int'(have_cur), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
